// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the 256-byte S memory in place through
// a single-port RAM with one-cycle read latency, six cycles per swap.
module ksa #(
  parameter int KEYLEN = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  output logic                  rdy,
  input  logic [8*KEYLEN-1:0]   key,
  output logic [7:0]            addr,
  input  logic [7:0]            rddata,
  output logic [7:0]            wrdata,
  output logic                  wren
);

  localparam int KIDX_W = (KEYLEN > 1) ? $clog2(KEYLEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    WAIT_I,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J
  } state_t;

  state_t                state, state_nxt;
  logic [7:0]            i, j;
  logic [KIDX_W-1:0]     kidx;
  logic [7:0]            si, sj;
  logic [8*KEYLEN-1:0]   key_q;

  // Byte 0 of the key sits in the most significant byte lane.
  function automatic logic [7:0] key_byte(input logic [8*KEYLEN-1:0] k,
                                          input logic [KIDX_W-1:0]   idx);
    logic [7:0] b;
    b = '0;
    for (int n = 0; n < KEYLEN; n++) begin
      if (idx == KIDX_W'(n)) b = k[8*(KEYLEN-1-n) +: 8];
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    addr      = 8'd0;
    wrdata    = 8'd0;
    wren      = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (en) state_nxt = RD_I;
      end
      RD_I: begin
        addr      = i;
        state_nxt = WAIT_I;
      end
      WAIT_I: begin
        addr      = i;
        state_nxt = RD_J;
      end
      RD_J: begin
        addr      = j;
        state_nxt = WAIT_J;
      end
      WAIT_J: begin
        addr      = j;
        state_nxt = WR_I;
      end
      WR_I: begin
        addr      = i;
        wrdata    = sj;
        wren      = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        addr      = j;
        wrdata    = si;
        wren      = 1'b1;
        state_nxt = (i == 8'hFF) ? IDLE : RD_I;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Loop indices: j accumulates in WAIT_I, i and the key index step in WR_J.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i    <= 8'd0;
      j    <= 8'd0;
      kidx <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (en) begin
            i    <= 8'd0;
            j    <= 8'd0;
            kidx <= '0;
          end
        end
        WAIT_I: j <= j + rddata + key_byte(key_q, kidx);
        WR_J: begin
          if (i == 8'hFF) begin
            i    <= 8'd0;
            j    <= 8'd0;
            kidx <= '0;
          end else begin
            i    <= i + 8'd1;
            kidx <= (kidx == KIDX_W'(KEYLEN-1)) ? '0 : kidx + KIDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && en) key_q <= key;
    if (state == WAIT_I)     si    <= rddata;
    if (state == WAIT_J)     sj    <= rddata;
  end

endmodule

// File: tb/tb_ksa.sv
// Directed bench for ksa: behavioural S memory, software KSA reference model.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;
  logic        preload;

  logic [7:0]  mem [256];
  logic [7:0]  exp_mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ksa #(.KEYLEN(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  typedef struct {
    logic [7:0] addr;
    logic       wren;
    logic [7:0] wrdata;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic sw_ksa(input logic [23:0] k);
    logic [7:0] jj, t, kb;
    for (int n = 0; n < 256; n++) exp_mem[n] = 8'(n);
    jj = 8'd0;
    for (int n = 0; n < 256; n++) begin
      kb = k[8*(2 - (n % 3)) +: 8];
      jj = jj + exp_mem[n] + kb;
      t = exp_mem[n];
      exp_mem[n] = exp_mem[jj];
      exp_mem[jj] = t;
    end
  endtask

  task automatic cmp_mem(input string name);
    int nbad;
    int first;
    nbad = 0;
    first = -1;
    for (int n = 0; n < 256; n++) begin
      if (mem[n] !== exp_mem[n]) begin
        nbad++;
        if (first < 0) first = n;
      end
    end
    if (first >= 0)
      $display("note %s: first differing byte %0d got %0d expected %0d",
               name, first, mem[first], exp_mem[first]);
    chk({name, "_bad_bytes"}, nbad, 0);
  endtask

  task automatic do_preload();
    @(negedge clk) preload = 1'b1;
    @(negedge clk) preload = 1'b0;
  endtask

  // Starts a run and counts rdy-low and wren cycles until rdy returns.
  task automatic do_run(input logic [23:0] k, input int dist_at,
                        output int lowc, output int wrc);
    key = k;
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    lowc = 0;
    wrc  = 0;
    while (!rdy && lowc < 3000) begin
      lowc++;
      if (wren) wrc++;
      if (lowc == dist_at) begin
        en  = 1'b1;
        key = 24'hFFFFFF;
      end else if (lowc == dist_at + 1) begin
        en = 1'b0;
      end
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc, wrc, high, wl;

    vecs[0]  = '{8'd0, 1'b0, 8'd0};
    vecs[1]  = '{8'd0, 1'b0, 8'd0};
    vecs[2]  = '{8'd0, 1'b0, 8'd0};
    vecs[3]  = '{8'd0, 1'b0, 8'd0};
    vecs[4]  = '{8'd0, 1'b1, 8'd0};
    vecs[5]  = '{8'd0, 1'b1, 8'd0};
    vecs[6]  = '{8'd1, 1'b0, 8'd0};
    vecs[7]  = '{8'd1, 1'b0, 8'd0};
    vecs[8]  = '{8'd4, 1'b0, 8'd0};
    vecs[9]  = '{8'd4, 1'b0, 8'd0};
    vecs[10] = '{8'd1, 1'b1, 8'd4};
    vecs[11] = '{8'd4, 1'b1, 8'd1};

    rst_n   = 1'b0;
    en      = 1'b0;
    key     = 24'h000000;
    preload = 1'b0;

    // Reset and idle
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("idle_rdy", rdy, 1);
      chk("idle_wren", wren, 0);
      chk("idle_addr", addr, 0);
      chk("idle_wrdata", wrdata, 0);
      @(negedge clk);
    end

    // First two iterations, table-driven
    do_preload();
    key = 24'h00033C;
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("it_c%0d_addr", c + 1), addr, vecs[c].addr);
      chk($sformatf("it_c%0d_wren", c + 1), wren, vecs[c].wren);
      if (vecs[c].wren) chk($sformatf("it_c%0d_wrdata", c + 1), wrdata, vecs[c].wrdata);
      chk($sformatf("it_c%0d_rdy", c + 1), rdy, 0);
      @(negedge clk);
    end
    wl = 0;
    while (!rdy && wl < 3000) begin
      wl++;
      @(negedge clk);
    end
    chk("it_finish_rdy", rdy, 1);

    // Full clean run
    sw_ksa(24'h00033C);
    do_preload();
    do_run(24'h00033C, -10, lowc, wrc);
    chk("full_low_cycles", lowc, 1536);
    chk("full_wren_cycles", wrc, 512);
    chk("full_rdy_after", rdy, 1);
    cmp_mem("full_mem");

    // en and key disturbed while busy
    do_preload();
    do_run(24'h00033C, 50, lowc, wrc);
    chk("busy_low_cycles", lowc, 1536);
    chk("busy_wren_cycles", wrc, 512);
    cmp_mem("busy_mem");

    // Reset mid-run
    do_preload();
    key = 24'h00033C;
    @(negedge clk) en = 1'b1;
    @(negedge clk) en = 1'b0;
    for (int c = 1; c < 100; c++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_rdy", rdy, 1);
    chk("rst_mid_wren", wren, 0);
    chk("rst_mid_addr", addr, 0);
    chk("rst_mid_wrdata", wrdata, 0);
    rst_n = 1'b1;
    wrc = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wren) wrc++;
    end
    chk("rst_mid_no_writes", wrc, 0);
    chk("rst_mid_rdy_hold", rdy, 1);
    do_preload();
    do_run(24'h00033C, -10, lowc, wrc);
    chk("rst_restart_low_cycles", lowc, 1536);
    cmp_mem("rst_restart_mem");

    // Back-to-back with en held high
    do_preload();
    key = 24'h00033C;
    @(negedge clk) en = 1'b1;
    @(negedge clk);
    chk("b2b_run1_busy", rdy, 0);
    wl = 0;
    while (!rdy && wl < 3000) begin
      wl++;
      @(negedge clk);
    end
    chk("b2b_run1_low_cycles", wl, 1536);
    high = 0;
    while (rdy && high < 10) begin
      high++;
      @(negedge clk);
    end
    chk("b2b_rdy_high_cycles", high, 1);
    chk("b2b_run2_first_addr", addr, 0);
    en = 1'b0;
    lowc = 0;
    while (!rdy && lowc < 3000) begin
      lowc++;
      @(negedge clk);
    end
    chk("b2b_run2_low_cycles", lowc, 1536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ksa.md
# ksa

Key-scheduling stage of the ARC4 datapath. It sits directly downstream of `init`: once `init` has filled the 256-byte S memory with s[i]=i, `ksa` permutes that memory in place using a 24-bit key. It shares the S memory's single port, driving `addr`/`wrdata`/`wren` and reading `rddata`. It uses the same `en`/`rdy` start handshake as `init`, so the top-level controller sequences both stages identically.

## Interface
- `KEYLEN`, default 3: key length in bytes; key byte k is `key[8*(KEYLEN-1-k) +: 8]`, so byte 0 is the MSB byte.
- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `en`  input  1  start request; sampled only while `rdy`=1.
- `rdy`  output  1  high when idle and able to accept `en`.
- `key`  input  8*KEYLEN (24)  secret key; latched when a start is accepted.
- `addr`  output  8  S memory address.
- `rddata`  input  8  S memory read data; valid in the cycle after `addr` is driven.
- `wrdata`  output  8  S memory write data.
- `wren`  output  1  S memory write enable.

## Operation
- Algorithm: j=0; for i=0..255: j=(j+s[i]+key[i mod KEYLEN]) mod 256; swap s[i], s[j]. All adds are 8-bit and wrap mod 256.
- States: IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J.
- IDLE: `rdy`=1, `wren`=0, `addr`=0, `wrdata`=0. If `en`=1, latch `key`, set i=0, j=0, and go to RD_I.
- RD_I: `addr`=i, `wren`=0. Go to WAIT_I.
- WAIT_I: `addr`=i. At the clock edge, si<=`rddata` and j<=j+`rddata`+keybyte(i mod KEYLEN). Go to RD_J.
- RD_J: `addr`=j (new value), `wren`=0. Go to WAIT_J.
- WAIT_J: `addr`=j. At the clock edge, sj<=`rddata`. Go to WR_I.
- WR_I: `addr`=i, `wrdata`=sj, `wren`=1. Go to WR_J.
- WR_J: `addr`=j, `wrdata`=si, `wren`=1. If i=255, go to IDLE. Otherwise i<=i+1 and go to RD_I.
- i==j case: both writes store the same value, so memory is unchanged. No special handling is required.
- The i counter must not wrap back to 0 and continue. Termination is detected at i=255 in WR_J.
- `en` is ignored while busy, and `key` changes after acceptance have no effect.
- Key index i mod KEYLEN is tracked with a separate 0..KEYLEN-1 counter (no divider).
- Reset (any state, including mid-run): next cycle is IDLE with `rdy`=1, `wren`=0, `addr`=0, `wrdata`=0, and i=j=0. No further writes are issued; memory is left partially permuted. A following `en` restarts from i=0, j=0.

## Timing
- Start: `en`=1 with `rdy`=1 at edge E. The cycle after E is RD_I for i=0, with `rdy`=0.
- Each iteration is exactly 6 cycles; the full run is 1536 cycles.
- `rdy` is low for exactly 1536 cycles and returns high in the cycle after the final WR_J.
- Back-to-back: if `en` is held high, `rdy` is high for exactly one cycle, then a new run starts with the current `key`.
- Writes happen only in WR_I and WR_J: 2 write cycles per iteration, 512 per run.
- Memory contract: single-port synchronous RAM with 1-cycle read latency. `ksa` never reads and writes in the same cycle.

## Test plan
- Reset/idle: hold `rst_n`=0 for 2 cycles, then release. Required: `rdy`=1, `wren`=0, `addr`=0, `wrdata`=0; with `en`=0 these hold indefinitely.
- First iterations: preload s[i]=i, set `key`=24'h00033C, pulse `en`.
  - i=0, cycles 1-6: `addr`=0,0,0,0,0,0; `wren`=1 only on cycles 5-6, with `wrdata`=0 both times.
  - i=1, cycles 7-12: `addr`=1,1,4,4,1,4; cycle 11 writes 4, cycle 12 writes 1.
- Full run: preload s[i]=i, `key`=24'h00033C. Required: `rdy` low for exactly 1536 cycles and exactly 512 `wren` cycles. Final memory must match a software KSA model byte-for-byte.
- Busy immunity: toggle `en` and change `key` to 24'hFFFFFF at cycle 50 of a run. Required: final memory identical to the undisturbed 24'h00033C result, and cycle count unchanged.
- Reset mid-run: assert `rst_n`=0 at cycle 100 of a run.
  - Next cycle: `rdy`=1 and `wren`=0, and `wren` stays low afterwards.
  - Re-preload memory and restart. Required: the result equals a clean full run.
- Back-to-back: hold `en`=1 across completion. Required: `rdy` high for exactly one cycle, then a second 1536-cycle run whose first `addr` is 0.
